// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU core and its multiplier.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per cycle over WIDTH cycles.
// The product is truncated to WIDTH+1 bits.
module alu_shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic             busy;

  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  // Done is raised during the final iteration so the caller can capture
  // the finished sum at the same edge that performs it.
  assign done    = busy && (cnt == CNT_LAST);
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {1'b0, a};
      mplier <= b;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential handshaked ALU with a registered WIDTH+1 bit result.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise op 111 reports err.
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for an operation
// ST_MUL  | shift-add multiply in progress (only with ALU_MUL_EN)
// ST_DONE | out_valid=1, result held until out_ready
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   res,
  output logic             err
);

  state_e         state, state_nxt;
  logic [WIDTH:0] res_q, res_nxt, res_c;
  logic           err_q, err_nxt, err_c;
  op_e            op;

  assign op = op_e'({s2, s1, s0});

`ifdef ALU_MUL_EN
  logic           mul_start;
  logic           mul_done;
  logic [WIDTH:0] mul_product;

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // Single-cycle datapath; the top bit carries carry, borrow or the last bit shifted out.
  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    case (op)
      OP_ADD: res_c = {1'b0, a} + {1'b0, b};
      OP_SUB: res_c = {1'b0, a} - {1'b0, b};
      OP_AND: res_c = {1'b0, a & b};
      OP_OR:  res_c = {1'b0, a | b};
      OP_XOR: res_c = {1'b0, a ^ b};
      OP_NOT: res_c = {1'b0, ~a};
      OP_SHL: res_c = {1'b0, a} << b[4:0];
      OP_MUL: begin
`ifdef ALU_MUL_EN
        res_c = '0;
`else
        res_c = '0;
        err_c = 1'b1;
`endif
      end
      default: res_c = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    res_nxt   = res_q;
    err_nxt   = err_q;
`ifdef ALU_MUL_EN
    mul_start = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_nxt = ST_MUL;
          end else
`endif
          begin
            res_nxt   = res_c;
            err_nxt   = err_c;
            state_nxt = ST_DONE;
          end
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        if (mul_done) begin
          res_nxt   = mul_product;
          err_nxt   = 1'b0;
          state_nxt = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      res_q <= res_nxt;
      err_q <= err_nxt;
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign res       = res_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: vector table, scoreboard queue and
// hand-written backpressure / reset sequences. Honours ALU_MUL_EN like the RTL.
module tb_alu_seq_core;

`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        s0, s1, s2;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] res;
  logic        err;

  alu_seq_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32:0] res;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [32:0] res;
    logic        err;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vt[14];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] mop);
    exp_t        e;
    logic [63:0] w;
    logic [4:0]  sh;
    e.err = 1'b0;
    e.lat = 1;
    e.res = '0;
    sh    = mb[4:0];
    case (mop)
      3'd0: e.res = {1'b0, ma} + {1'b0, mb};
      3'd1: e.res = {1'b0, ma} - {1'b0, mb};
      3'd2: e.res = {1'b0, ma & mb};
      3'd3: e.res = {1'b0, ma | mb};
      3'd4: e.res = {1'b0, ma ^ mb};
      3'd5: e.res = {1'b0, ~ma};
      3'd6: begin
        w     = {32'd0, ma} << sh;
        e.res = w[32:0];
      end
      default: begin
        if (MUL_ON) begin
          w     = {32'd0, ma} * {32'd0, mb};
          e.res = w[32:0];
          e.lat = 33;
        end else begin
          e.err = 1'b1;
        end
      end
    endcase
    return e;
  endfunction

  // Issue one op; hold = cycles out_ready stays low after out_valid rises.
  task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                        input logic [2:0] top, input exp_t ex, input int hold);
    int   lat;
    int   tmo;
    exp_t e;
    tmo = 0;
    while (!in_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    chk({nm, ".ready_wait"}, 64'(in_ready), 64'd1);
    a         = ta;
    b         = tb;
    {s2, s1, s0} = top;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    sb.push_back(ex);
    @(negedge clk);
    in_valid     = 1'b0;
    a            = $urandom;
    b            = $urandom;
    {s2, s1, s0} = 3'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk({nm, ".lat"}, 64'(lat), 64'(e.lat));
    chk({nm, ".res"}, 64'(res), 64'(e.res));
    chk({nm, ".err"}, 64'(err), 64'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, ".hold_res"}, 64'(res), 64'(e.res));
      chk({nm, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      chk({nm, ".hold_out_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, ".post_out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, ".post_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    vt[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 33'h1_0000_0000, 1'b0, 1};
    vt[1]  = '{32'h0000_0001, 32'h0000_0002, 3'd1, 33'h1_FFFF_FFFF, 1'b0, 1};
    vt[2]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2, 33'h0_00F0_00F0, 1'b0, 1};
    vt[3]  = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'd3, 33'h0_FFFF_FFFF, 1'b0, 1};
    vt[4]  = '{32'hFFFF_0000, 32'h0F0F_0F0F, 3'd4, 33'h0_F0F0_0F0F, 1'b0, 1};
    vt[5]  = '{32'h1234_5678, 32'hDEAD_BEEF, 3'd5, 33'h0_EDCB_A987, 1'b0, 1};
    vt[6]  = '{32'h8000_0001, 32'h0000_0001, 3'd6, 33'h1_0000_0002, 1'b0, 1};
    vt[7]  = '{32'h8000_0001, 32'h0000_0000, 3'd6, 33'h0_8000_0001, 1'b0, 1};
    vt[8]  = '{32'h0000_0003, 32'hFFFF_FFE0, 3'd6, 33'h0_0000_0003, 1'b0, 1};
    vt[9]  = '{32'h0000_0003, 32'h0000_001F, 3'd6, 33'h1_8000_0000, 1'b0, 1};
    vt[10] = MUL_ON ? '{32'h0001_0000, 32'h0001_0000, 3'd7, 33'h1_0000_0000, 1'b0, 33}
                    : '{32'h0001_0000, 32'h0001_0000, 3'd7, 33'h0, 1'b1, 1};
    vt[11] = MUL_ON ? '{32'h0000_0000, 32'hFFFF_FFFF, 3'd7, 33'h0, 1'b0, 33}
                    : '{32'h0000_0000, 32'hFFFF_FFFF, 3'd7, 33'h0, 1'b1, 1};
    vt[12] = MUL_ON ? '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 33'h0_0000_0001, 1'b0, 33}
                    : '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 33'h0, 1'b1, 1};
    vt[13] = MUL_ON ? '{32'h0000_0003, 32'h0000_0005, 3'd7, 33'h0_0000_000F, 1'b0, 33}
                    : '{32'h0000_0003, 32'h0000_0005, 3'd7, 33'h0, 1'b1, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; {s2, s1, s0} = 3'd0;
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.res", 64'(res), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      e.res = vt[i].res;
      e.err = vt[i].err;
      e.lat = vt[i].lat;
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].op, e, 0);
    end

    for (int i = 0; i < 10; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 3'($urandom_range(0, 7));
      run_op($sformatf("rnd%0d", i), ra, rb, rop, model(ra, rb, rop), 0);
    end

    e.res = 33'h0_FFFF_FFFF; e.err = 1'b0; e.lat = 1;
    run_op("bp_or", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'd3, e, 5);

    // Reset while MUL (or DONE without the multiplier) is in flight.
    a = 32'd3; b = 32'd5; {s2, s1, s0} = 3'd7;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    chk("midrst.busy_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    chk("midrst.res", 64'(res), 64'd0);
    chk("midrst.err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    e.res = 33'd5; e.err = 1'b0; e.lat = 1;
    run_op("post_rst_add", 32'd2, 32'd3, 3'd0, e, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
